// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone arbiter in front of a single RAM slave.
// Round-robin or irq-priority arbitration, grant locking, and a saturating ack timeout.
module wb_rr_arbiter #(
  parameter int                   ADDR_SIZE      = 16,
  parameter int                   WORD_SIZE      = 32,
  parameter int                   TIMEOUT_CYCLES = 255,
  parameter logic [WORD_SIZE-1:0] ERR_WORD       = 32'hDEAD_BEEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Irq_pending,
  input  logic [ADDR_SIZE-1:0] S_wb_ctrl_addr,
  input  logic                 S_wb_ctrl_cs,
  input  logic                 S_wb_ctrl_we,
  input  logic [WORD_SIZE-1:0] S_wb_ctrl_wdata,
  output logic [WORD_SIZE-1:0] S_wb_ctrl_rdata,
  output logic                 S_wb_ctrl_ack,
  input  logic [ADDR_SIZE-1:0] S_wb_core_addr,
  input  logic                 S_wb_core_cs,
  input  logic                 S_wb_core_we,
  input  logic [WORD_SIZE-1:0] S_wb_core_wdata,
  output logic [WORD_SIZE-1:0] S_wb_core_rdata,
  output logic                 S_wb_core_ack,
  output logic [ADDR_SIZE-1:0] M_wb_ram_addr,
  output logic                 M_wb_ram_cs,
  output logic                 M_wb_ram_we,
  output logic [WORD_SIZE-1:0] M_wb_ram_wdata,
  input  logic [WORD_SIZE-1:0] M_wb_ram_rdata,
  input  logic                 M_wb_ram_ack,
  output logic                 Bus_err,
  output logic [1:0]           Grant
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GNT_CTRL = 2'b01,
    GNT_CORE = 2'b10
  } state_e;

  // Timeout fires on the cycle whose pre-increment count is TIMEOUT_CYCLES-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic           last_ctrl_q, last_ctrl_d;
  logic [7:0]     cnt_q, cnt_d;

  logic                 gnt_ctrl_s, gnt_core_s, granted_s;
  logic                 sel_cs_s, sel_we_s;
  logic [ADDR_SIZE-1:0] sel_addr_s;
  logic [WORD_SIZE-1:0] sel_wdata_s;
  logic                 timeout_s, done_s, resp_ack_s;
  logic [WORD_SIZE-1:0] resp_rdata_s;

  // Gating with Rst keeps every bus output quiet while reset is held.
  assign gnt_ctrl_s = Rst & (state_q == GNT_CTRL);
  assign gnt_core_s = Rst & (state_q == GNT_CORE);
  assign granted_s  = gnt_ctrl_s | gnt_core_s;

  // Request mux: pick the granted master's request fields.
  always_comb begin
    sel_cs_s    = 1'b0;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (gnt_ctrl_s) begin
      sel_cs_s    = S_wb_ctrl_cs;
      sel_we_s    = S_wb_ctrl_we;
      sel_addr_s  = S_wb_ctrl_addr;
      sel_wdata_s = S_wb_ctrl_wdata;
    end else if (gnt_core_s) begin
      sel_cs_s    = S_wb_core_cs;
      sel_we_s    = S_wb_core_we;
      sel_addr_s  = S_wb_core_addr;
      sel_wdata_s = S_wb_core_wdata;
    end else begin
      sel_cs_s    = 1'b0;
    end
  end

  // A real ack always beats a timeout in the same cycle.
  assign timeout_s    = granted_s & sel_cs_s & ~M_wb_ram_ack & (cnt_q >= TO_LAST);
  assign done_s       = granted_s & (~sel_cs_s | M_wb_ram_ack | timeout_s);
  assign resp_ack_s   = granted_s & (M_wb_ram_ack | timeout_s);
  assign resp_rdata_s = !granted_s ? '0 : (timeout_s ? ERR_WORD : M_wb_ram_rdata);

  assign M_wb_ram_cs     = sel_cs_s & ~timeout_s;
  assign M_wb_ram_we     = sel_we_s;
  assign M_wb_ram_addr   = sel_addr_s;
  assign M_wb_ram_wdata  = sel_wdata_s;
  assign S_wb_ctrl_ack   = gnt_ctrl_s & resp_ack_s;
  assign S_wb_ctrl_rdata = gnt_ctrl_s ? resp_rdata_s : '0;
  assign S_wb_core_ack   = gnt_core_s & resp_ack_s;
  assign S_wb_core_rdata = gnt_core_s ? resp_rdata_s : '0;
  assign Bus_err         = timeout_s;
  assign Grant           = grant_q;

  // Next-state: arbitration in IDLE, completion/abort/timeout while granted.
  always_comb begin
    state_d     = state_q;
    last_ctrl_d = last_ctrl_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (S_wb_ctrl_cs && S_wb_core_cs) begin
          if (Irq_pending || !last_ctrl_q) begin
            state_d = GNT_CTRL;
          end else begin
            state_d = GNT_CORE;
          end
        end else if (S_wb_ctrl_cs) begin
          state_d = GNT_CTRL;
        end else if (S_wb_core_cs) begin
          state_d = GNT_CORE;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_CTRL, GNT_CORE: begin
        if (done_s) begin
          state_d     = IDLE;
          last_ctrl_d = (state_q == GNT_CTRL);
          cnt_d       = 8'd0;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    grant_d = 2'(state_d);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      last_ctrl_q <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_ctrl_q <= last_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized bench for wb_rr_arbiter against a transaction-level owner/wait-count model.
module tb_wb_rr_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_s = 1'b0, irq_s = 1'b0;
  logic [AW-1:0] c_addr_s = '0, k_addr_s = '0, m_addr_s;
  logic          c_cs_s = 1'b0, c_we_s = 1'b0, k_cs_s = 1'b0, k_we_s = 1'b0;
  logic [DW-1:0] c_wd_s = '0, k_wd_s = '0, m_wd_s;
  logic [DW-1:0] c_rd_s, k_rd_s;
  logic          c_ack_s, k_ack_s, m_cs_s, m_we_s;
  logic [DW-1:0] r_rd_s = '0;
  logic          r_ack_s = 1'b0, berr_s;
  logic [1:0]    grant_s;

  int total = 0, bad = 0;

  // model: owner 0 none / 1 ctrl / 2 core (matches Grant code), last winner, granted cycles so far
  int owner = 0, last = 2, waited = 0;
  logic [1:0]    obs_grant;
  logic          obs_c_ack, obs_k_ack, obs_berr, obs_mcs;
  logic [DW-1:0] obs_k_rd;

  wb_rr_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .TIMEOUT_CYCLES(TO), .ERR_WORD(ERR)) dut (
    .Clk(clk), .Rst(rst_s), .Irq_pending(irq_s),
    .S_wb_ctrl_addr(c_addr_s), .S_wb_ctrl_cs(c_cs_s), .S_wb_ctrl_we(c_we_s),
    .S_wb_ctrl_wdata(c_wd_s), .S_wb_ctrl_rdata(c_rd_s), .S_wb_ctrl_ack(c_ack_s),
    .S_wb_core_addr(k_addr_s), .S_wb_core_cs(k_cs_s), .S_wb_core_we(k_we_s),
    .S_wb_core_wdata(k_wd_s), .S_wb_core_rdata(k_rd_s), .S_wb_core_ack(k_ack_s),
    .M_wb_ram_addr(m_addr_s), .M_wb_ram_cs(m_cs_s), .M_wb_ram_we(m_we_s),
    .M_wb_ram_wdata(m_wd_s), .M_wb_ram_rdata(r_rd_s), .M_wb_ram_ack(r_ack_s),
    .Bus_err(berr_s), .Grant(grant_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic          g_cs, g_we, to_hit;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd, rd;
    logic          e_mcs, e_mwe, e_cack, e_kack, e_berr;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwd, e_crd, e_krd;
    int n_owner, n_last, n_waited;
    @(negedge clk);
    e_mcs = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwd = '0;
    e_cack = 1'b0; e_kack = 1'b0; e_crd = '0; e_krd = '0; e_berr = 1'b0; to_hit = 1'b0;
    n_owner = owner; n_last = last; n_waited = waited;
    if (!rst_s) begin
      n_owner = 0; n_last = 2; n_waited = 0;
    end else if (owner == 0) begin
      n_waited = 0;
      if (c_cs_s && k_cs_s) n_owner = (irq_s || last == 2) ? 1 : 2;
      else if (c_cs_s)      n_owner = 1;
      else if (k_cs_s)      n_owner = 2;
    end else begin
      g_cs   = (owner == 1) ? c_cs_s   : k_cs_s;
      g_we   = (owner == 1) ? c_we_s   : k_we_s;
      g_addr = (owner == 1) ? c_addr_s : k_addr_s;
      g_wd   = (owner == 1) ? c_wd_s   : k_wd_s;
      to_hit = g_cs && !r_ack_s && (waited + 1 >= TO);
      e_mcs = g_cs && !to_hit; e_mwe = g_we; e_maddr = g_addr; e_mwd = g_wd;
      rd = to_hit ? ERR : r_rd_s;
      if (owner == 1) begin e_cack = r_ack_s || to_hit; e_crd = rd; end
      else            begin e_kack = r_ack_s || to_hit; e_krd = rd; end
      e_berr = to_hit;
      if (!g_cs || r_ack_s || to_hit) begin
        n_owner = 0; n_last = owner; n_waited = 0;
      end else begin
        n_waited = waited + 1;
      end
    end
    check_eq("grant", 32'(grant_s), 32'(owner));
    check_eq("m_cs", 32'(m_cs_s), 32'(e_mcs));
    check_eq("m_we", 32'(m_we_s), 32'(e_mwe));
    check_eq("m_addr", 32'(m_addr_s), 32'(e_maddr));
    check_eq("m_wdata", m_wd_s, e_mwd);
    check_eq("ctrl_ack", 32'(c_ack_s), 32'(e_cack));
    check_eq("core_ack", 32'(k_ack_s), 32'(e_kack));
    // on a timed-out write the returned word is don't-care
    if (!(to_hit && e_mwe)) begin
      check_eq("ctrl_rdata", c_rd_s, e_crd);
      check_eq("core_rdata", k_rd_s, e_krd);
    end
    check_eq("bus_err", 32'(berr_s), 32'(e_berr));
    obs_c_ack = c_ack_s; obs_k_ack = k_ack_s; obs_berr = berr_s;
    obs_mcs = m_cs_s; obs_k_rd = k_rd_s;
    @(posedge clk);
    #1;
    owner = n_owner; last = n_last; waited = n_waited;
    obs_grant = grant_s;
  endtask

  task automatic quiet();
    c_cs_s = 1'b0; k_cs_s = 1'b0; r_ack_s = 1'b0; irq_s = 1'b0; rst_s = 1'b1;
    for (int i = 0; i < 8 && owner != 0; i++) step();
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step();
    check_eq("rst_grant", 32'(obs_grant), 32'h0);
    rst_s = 1'b1;

    // first arbitration after reset: ctrl wins, then core
    c_cs_s = 1'b1; k_cs_s = 1'b1; c_addr_s = 16'h0011; k_addr_s = 16'h0022;
    r_rd_s = 32'h1234_5678;
    step();
    check_eq("rr_first", 32'(obs_grant), 32'h1);
    step();
    r_ack_s = 1'b1;
    step();
    check_eq("rr_idle", 32'(obs_grant), 32'h0);
    r_ack_s = 1'b0;
    step();
    check_eq("rr_second", 32'(obs_grant), 32'h2);
    quiet();

    // irq priority starves core
    c_cs_s = 1'b1; k_cs_s = 1'b1; irq_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_ack_s = (owner != 0);
      step();
      check_eq("irq_seq", 32'(obs_grant), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    quiet();

    // irq does not preempt a core grant
    k_cs_s = 1'b1; k_we_s = 1'b1;
    step();
    irq_s = 1'b1; c_cs_s = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("lock", 32'(obs_grant), 32'h2);
    end
    r_ack_s = 1'b1;
    step();
    r_ack_s = 1'b0;
    step();
    check_eq("lock_next", 32'(obs_grant), 32'h1);
    quiet();

    // core read timeout
    k_cs_s = 1'b1; k_we_s = 1'b0; k_addr_s = 16'h00A5;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("to_early", 32'(obs_berr), 32'h0);
    end
    step();
    check_eq("to_ack", 32'(obs_k_ack), 32'h1);
    check_eq("to_rdata", obs_k_rd, ERR);
    check_eq("to_berr", 32'(obs_berr), 32'h1);
    check_eq("to_mcs", 32'(obs_mcs), 32'h0);
    check_eq("to_idle", 32'(obs_grant), 32'h0);
    quiet();

    // ctrl abort, then core served
    c_cs_s = 1'b1;
    step();
    c_cs_s = 1'b0; k_cs_s = 1'b1;
    step();
    check_eq("abort_ack", 32'(obs_c_ack), 32'h0);
    check_eq("abort_berr", 32'(obs_berr), 32'h0);
    check_eq("abort_idle", 32'(obs_grant), 32'h0);
    step();
    check_eq("abort_next", 32'(obs_grant), 32'h2);

    // reset during a pending core write
    k_we_s = 1'b1; rst_s = 1'b0;
    step();
    check_eq("rst_mid", 32'(obs_grant), 32'h0);
    k_cs_s = 1'b0;
    step();
    check_eq("rst_mid_ack", 32'(obs_k_ack), 32'h0);
    quiet();

    for (int n = 0; n < 3000; n++) begin
      rst_s    = ($urandom_range(0, 99) >= 2);
      irq_s    = $urandom_range(0, 1);
      c_cs_s   = ($urandom_range(0, 99) < 85);
      k_cs_s   = ($urandom_range(0, 99) < 85);
      c_we_s   = $urandom_range(0, 1);
      k_we_s   = $urandom_range(0, 1);
      c_addr_s = AW'($urandom);
      k_addr_s = AW'($urandom);
      c_wd_s   = $urandom;
      k_wd_s   = $urandom;
      r_rd_s   = $urandom;
      r_ack_s  = ($urandom_range(0, 99) < 25);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
